// File: rtl/adc_pkg.sv
// Shared definitions for the ADC start/EOC/OE controller and its bench-side ADC model.
package adc_pkg;

    localparam int ADC_W       = 12;
    localparam int DEF_START_W = 2;
    localparam int DEF_OE_W    = 2;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        OE_HIGH   = 3'd4,
        CAPTURE   = 3'd5
    } adc_state_e;

endpackage

// File: rtl/adc_ctrl_tick_gen.sv
// Auto-sample period timer: counts 0..SAMPLE_DIV-1 while enabled, held at zero otherwise.
module adc_tick_gen #(
    parameter int SAMPLE_DIV = 1000,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Period counter, restarting from zero whenever sampling is disabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/adc_ctrl.sv
// ADC handshake initiator: start pulse, EOC wait with watchdog, OE pulse, capture.
// Auto ticks arriving mid-conversion queue one deep; a second one is reported as overrun.
module adc_ctrl
    import adc_pkg::*;
#(
    parameter int START_W    = DEF_START_W,
    parameter int OE_W       = DEF_OE_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int SAMPLE_DIV = 1000,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             auto_en,
    input  logic             sample_req,
    input  logic             EOC,
    input  logic [ADC_W-1:0] adc_data,
    output logic             start,
    output logic             OE,
    output logic [ADC_W-1:0] sample_data,
    output logic             sample_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_W - 1);
    localparam logic [CNT_W-1:0] OE_END    = CNT_W'(OE_W - 1);
    localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(TIMEOUT - 1);

    adc_state_e       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             pending_r, pending_s;
    logic             tick_s, trigger_s, timeout_s, capture_s, overrun_s;

    adc_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .CNT_W      (CNT_W)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .en   (auto_en),
        .tick (tick_s)
    );

    assign trigger_s = sample_req | tick_s | pending_r;

    // Next-state logic; cnt_s restarts at zero on every state change
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + ONE;
        timeout_s = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (trigger_s) state_s = START;
                else           state_s = IDLE;
            end
            START: begin
                if (cnt_r == START_END) begin
                    state_s = WAIT_BUSY;
                    cnt_s   = '0;
                end else begin
                    state_s = START;
                end
            end
            WAIT_BUSY: begin
                if (!EOC) begin
                    state_s = WAIT_DONE;
                    cnt_s   = '0;
                end else if (cnt_r == WAIT_END) begin
                    state_s   = IDLE;
                    cnt_s     = '0;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (EOC) begin
                    state_s = OE_HIGH;
                    cnt_s   = '0;
                end else if (cnt_r == WAIT_END) begin
                    state_s   = IDLE;
                    cnt_s     = '0;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            OE_HIGH: begin
                if (cnt_r == OE_END) begin
                    state_s = CAPTURE;
                    cnt_s   = '0;
                end else begin
                    state_s = OE_HIGH;
                end
            end
            CAPTURE: begin
                state_s   = IDLE;
                cnt_s     = '0;
                capture_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Pending/overrun: in IDLE any pending tick is consumed by the conversion it triggers
    always_comb begin
        pending_s = pending_r;
        overrun_s = 1'b0;
        if (state_r == IDLE) begin
            pending_s = 1'b0;
        end else if (tick_s) begin
            if (pending_r) overrun_s = 1'b1;
            else           pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end
    end

    // State, counter and pending flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pending_r <= pending_s;
        end
    end

    // Registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start        <= 1'b0;
            OE           <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else begin
            start        <= (state_s == START);
            OE           <= (state_s == OE_HIGH);
            busy         <= (state_s != IDLE);
            timeout_err  <= timeout_s;
            overrun      <= overrun_s;
            sample_valid <= capture_s;
            if (capture_s) sample_data <= adc_data;
            else           sample_data <= sample_data;
        end
    end

endmodule

// File: doc/adc_ctrl.md
Name: adc_ctrl

Overview:
- Initiator for the ADC start/EOC/OE handshake; drives a 12-bit converter and returns samples to the PID datapath.
- Starts a conversion on request or on an internal sample-period tick, waits for end-of-conversion, pulses OE, captures the result and presents it with a one-cycle valid.
- Sits between the ADC and the PID error computation. Includes a timeout watchdog and overrun detection.

Parameters:
- START_W, 2: cycles `start` is held high per conversion (≥1).
- OE_W, 2: cycles `OE` is held high (≥1).
- TIMEOUT, 64: maximum cycles allowed in each EOC-wait state before aborting.
- SAMPLE_DIV, 1000: auto-sample period in clk cycles (≥ one full conversion).
- CNT_W, 32: width of the internal counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- auto_en  in  1  enables periodic sampling every SAMPLE_DIV cycles
- sample_req  in  1  single-cycle manual conversion request
- EOC  in  1  ADC end-of-conversion (high = idle/done, low = converting)
- adc_data  in  12  ADC result bus
- start  out  1  conversion start to ADC
- OE  out  1  output enable to ADC
- sample_data  out  12  last captured sample
- sample_valid  out  1  one-cycle strobe when sample_data updates
- busy  out  1  high whenever state ≠ IDLE
- timeout_err  out  1  one-cycle strobe on watchdog abort
- overrun  out  1  one-cycle strobe when an auto tick is dropped

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE.
  - start=0, OE=0, sample_data=0, sample_valid=0, busy=0, timeout_err=0, overrun=0.
  - All counters and the pending flag cleared.
  - Reset mid-conversion aborts immediately; no capture occurs.
- All outputs are registered.
- States are IDLE, START, WAIT_BUSY, WAIT_DONE, OE_HIGH, CAPTURE.
- Trigger is `sample_req`, a period tick, or a set pending flag.
  - Trigger seen in IDLE at cycle T: enter START; start=1 from T+1.
- START: start=1 for exactly START_W cycles, then start=0 and go to WAIT_BUSY.
- WAIT_BUSY: wait for EOC==0, then go to WAIT_DONE.
- WAIT_DONE: wait for EOC==1, then go to OE_HIGH.
- Watchdog:
  - Separate count of TIMEOUT cycles in each of WAIT_BUSY and WAIT_DONE; the counter is cleared on entry to each state.
  - On expiry: timeout_err=1 for one cycle, go to IDLE, sample_data unchanged.
- OE_HIGH: OE=1 for exactly OE_W cycles, then go to CAPTURE.
- CAPTURE:
  - OE=0.
  - sample_data<=adc_data, sampled on the first cycle after OE falls.
  - sample_valid=1 for that cycle only, then go to IDLE.
- Latency: T to sample_valid = 1 + START_W + busy-wait + conversion + OE_W + 1 cycles.
- Period timer:
  - Free-runs 0..SAMPLE_DIV-1 while auto_en=1 and cleared while auto_en=0.
  - Tick at count SAMPLE_DIV-1.
- Tick while busy: set pending (one deep). Pending is serviced on the next IDLE cycle and cleared when START is entered.
- Tick while busy with pending already set: overrun=1 for one cycle; the tick is dropped.
- sample_req while busy is ignored; it is neither queued nor flagged.
- sample_req and tick in the same IDLE cycle: a single conversion; pending is not set.
- EOC already low on entry to WAIT_BUSY advances on the next cycle.
- sample_data holds its value until the next successful CAPTURE.

Decomposition:
- Shared package `adc_pkg`:
  - State encoding constants for the six states.
  - ADC_W=12.
  - Default START_W, OE_W and TIMEOUT values, shared with the ADC model.
- One sub-module, `adc_tick_gen`: SAMPLE_DIV period counter with enable, producing the single-cycle tick.
- Pending/overrun logic and the FSM stay in adc_ctrl.

Test Plan:
1. Manual sample: ADC model with convert_time=10 and adc_data=12'hA5C; pulse sample_req -> start high 2 cycles, OE high 2 cycles, sample_data=12'hA5C, one sample_valid pulse, busy low afterwards.
2. Auto mode: SAMPLE_DIV=50, auto_en=1 for 500 cycles, data incrementing -> exactly 10 sample_valid pulses 50 cycles apart, each with the current data.
3. Timeout: EOC held high permanently, sample_req -> timeout_err pulse at the 64th WAIT_BUSY cycle; return to IDLE; sample_data unchanged (0 after reset).
4. Overrun: SAMPLE_DIV=20, conversion stretched to 50 cycles -> first tick sets pending, second tick pulses overrun; the next conversion starts the cycle after IDLE is re-entered.
5. Ignored request: sample_req pulsed during WAIT_DONE -> no extra conversion and no overrun; exactly one sample_valid.
6. Reset mid-OE_HIGH: rstn low for 1 cycle -> start/OE=0 immediately, sample_data=0, no sample_valid; a later sample_req completes normally.
